stack_lifo: RTL and testbench
=============================

// Module: stack_lifo
// PURPOSE
//   Synchronous LIFO stack with registered pop data. It buffers small data words
//   for last-in/first-out retrieval by a controlling FSM. A single-cycle push
//   stores din on top. A single-cycle pop loads the top entry into dout.
// PARAMETERS
//   WIDTH  4  data word width in bits
//   DEPTH  8  number of entries (>=2); count width CW = $clog2(DEPTH+1)
// PORTS
//   clk    in   1      system clock, all state changes on rising edge
//   nrst   in   1      reset, synchronous, active-low
//   push   in   1      write din onto top of stack this cycle
//   pop    in   1      remove top entry into dout this cycle
//   din    in   WIDTH  push data
//   dout   out  WIDTH  last popped value (registered, held until next pop)
//   empty  out  1      count == 0 (combinational from count register)
//   full   out  1      count == DEPTH (combinational from count register)
//   count  out  CW     number of valid entries
// BEHAVIOUR
//   - One clock; reset is synchronous and active-low (nrst sampled on clk rise).
//   - Reset: count=0, dout=0, empty=1, full=0. Memory contents are don't-care.
//     Reset applied mid-operation discards all entries on that edge.
//   - Storage: mem[0..DEPTH-1]; top entry = mem[count-1]; pointer = count.
//   - push=1, pop=0, !full: mem[count] <= din; count <= count+1. dout unchanged.
//   - push=1, pop=0, full: overflow, ignored. Memory, count and dout unchanged.
//   - pop=1, push=0, !empty: dout <= mem[count-1]; count <= count-1.
//     Latency: popped value is visible on dout immediately after the pop edge.
//   - pop=1, push=0, empty: underflow, ignored. dout holds its previous value.
//   - push=1, pop=1, !empty: swap. dout <= mem[count-1]; mem[count-1] <= din;
//     count unchanged.
//   - push=1, pop=1, empty: bypass. dout <= din; count unchanged; nothing stored.
//   - push=0, pop=0: hold all state.
//   - No wrap-around: count is saturated between 0 and DEPTH by the rules above.
//   - dout never goes X after reset. No combinational path from din to dout.
// CONFIGURATION
//   STACK_ERR_EN defined: adds output port err (1 bit), a sticky flag.
//     err is set on the edge of any ignored overflow push or underflow pop.
//     It is cleared only by reset (reset value 0). Swap and bypass never set it.
//   STACK_ERR_EN undefined: err port and logic absent; all other behaviour is
//     identical.
// TESTING
//   1. Hold nrst=0 for 2 edges -> dout=0, count=0, empty=1, full=0.
//   2. Push 3,7,12,15 (one-cycle pulses) -> count=4. Then 4 single pops ->
//      dout reads 15,12,7,3 after successive pop edges; empty=1 at end.
//   3. From empty, pop -> dout keeps its last value (3), count=0;
//      with STACK_ERR_EN, err=1.
//   4. Push 1..8 (DEPTH=8) -> full=1. Push 9 -> ignored, count=8. Pop 8 times ->
//      dout reads 8 down to 1.
//   5. Stack holds [5,6]; assert push=1, pop=1, din=9 -> dout=6, count=2.
//      Next pop -> dout=9. Empty stack with push=1, pop=1, din=4 -> dout=4,
//      count=0.
//   6. Push 2 values, drive nrst=0 for 1 edge -> count=0, dout=0, err=0.
//      A following pop is an ignored underflow.

Source files
------------

// File: rtl/stack_lifo.sv
// Synchronous LIFO stack with registered pop data, swap and bypass handling.
// Optional sticky overflow/underflow flag enabled by defining STACK_ERR_EN.
module stack_lifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
`ifdef STACK_ERR_EN
  output logic             err,
`endif
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    ptr;
  logic [AW-1:0]    top;
  logic             do_push;
  logic             do_pop;
  logic             do_swap;
  logic             do_bypass;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // ptr/top are only used when the matching op is legal, so truncation is safe.
  assign ptr = AW'(count);
  assign top = AW'(count - CW'(1));

  assign do_push   = push & ~pop & ~full;
  assign do_pop    = pop & ~push & ~empty;
  assign do_swap   = push & pop & ~empty;
  assign do_bypass = push & pop & empty;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count <= '0;
      dout  <= '0;
    end else begin
      if (do_push) begin
        count <= count + CW'(1);
      end else if (do_pop) begin
        count <= count - CW'(1);
        dout  <= mem[top];
      end else if (do_swap) begin
        dout  <= mem[top];
      end else if (do_bypass) begin
        dout  <= din;
      end
    end
  end

  // Storage is not reset; contents beyond count are never observed.
  always_ff @(posedge clk) begin
    if (nrst) begin
      if (do_push) begin
        mem[ptr] <= din;
      end else if (do_swap) begin
        mem[top] <= din;
      end
    end
  end

`ifdef STACK_ERR_EN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      err <= 1'b0;
    end else if ((push & ~pop & full) | (pop & ~push & empty)) begin
      err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_stack_lifo.sv
// Scoreboard bench for stack_lifo: a queue-based stack model predicts each edge,
// a monitor compares dout/count/flags one delta after every rising edge.
module tb_stack_lifo;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int CW    = 4;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
`ifdef STACK_ERR_EN
  logic             err;
`endif

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk   (clk),
    .nrst  (nrst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .empty (empty),
    .full  (full),
`ifdef STACK_ERR_EN
    .err   (err),
`endif
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dout;
    int count;
    int empty;
    int full;
    int err;
  } exp_t;

  exp_t exp_q[$];
  int   stk[$];
  int   m_dout = 0;
  int   m_err = 0;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one cycle of stimulus and record what the stack must look like after the edge.
  task automatic step(input bit r, input bit pu, input bit po, input int d);
    exp_t e;
    @(negedge clk);
    nrst = r;
    push = pu;
    pop  = po;
    din  = WIDTH'(d);
    if (!r) begin
      stk.delete();
      m_dout = 0;
      m_err  = 0;
    end else if (pu && !po) begin
      if (stk.size() < DEPTH) stk.push_back(d);
      else m_err = 1;
    end else if (po && !pu) begin
      if (stk.size() > 0) m_dout = stk.pop_back();
      else m_err = 1;
    end else if (pu && po) begin
      if (stk.size() > 0) begin
        m_dout = stk.pop_back();
        stk.push_back(d);
      end else begin
        m_dout = d;
      end
    end
    e.dout  = m_dout;
    e.count = stk.size();
    e.empty = (stk.size() == 0) ? 1 : 0;
    e.full  = (stk.size() == DEPTH) ? 1 : 0;
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dout",  int'(dout),  e.dout);
        check("count", int'(count), e.count);
        check("empty", int'(empty), e.empty);
        check("full",  int'(full),  e.full);
`ifdef STACK_ERR_EN
        check("err",   int'(err),   e.err);
`endif
      end
    end
  end

  initial begin : stimulus
    int vals[4];
    int r;
    vals[0] = 3; vals[1] = 7; vals[2] = 12; vals[3] = 15;

    // reset held for two edges
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // push four values, pop them back in reverse
    foreach (vals[i]) step(1'b1, 1'b1, 1'b0, vals[i]);
    repeat (4) step(1'b1, 1'b0, 1'b1, 0);

    // underflow from empty keeps dout
    step(1'b1, 1'b0, 1'b1, 0);
    idle();

    // fill, overflow, drain
    for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b1, 1'b0, i);
    step(1'b1, 1'b1, 1'b0, 9);
    repeat (DEPTH) step(1'b1, 1'b0, 1'b1, 0);

    // swap on [5,6] then bypass on empty
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b1, 1'b0, 5);
    step(1'b1, 1'b1, 1'b0, 6);
    step(1'b1, 1'b1, 1'b1, 9);
    step(1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b1, 4);
    idle();

    // mid-operation reset discards entries, then an ignored underflow
    step(1'b1, 1'b1, 1'b0, 10);
    step(1'b1, 1'b1, 1'b0, 11);
    step(1'b0, 1'b0, 1'b0, 0);
    step(1'b1, 1'b0, 1'b1, 0);
    idle();

    // randomized traffic with drifting push bias so both boundaries are visited
    for (int n = 0; n < 600; n++) begin
      int bias;
      bias = ((n / 50) % 2 == 0) ? 70 : 30;
      r = int'($urandom_range(99));
      if ($urandom_range(127) == 0) begin
        step(1'b0, 1'b0, 1'b0, 0);
      end else if (r < 10) begin
        step(1'b1, 1'b1, 1'b1, int'($urandom_range(15)));
      end else if (r < 15) begin
        idle();
      end else if (int'($urandom_range(99)) < bias) begin
        step(1'b1, 1'b1, 1'b0, int'($urandom_range(15)));
      end else begin
        step(1'b1, 1'b0, 1'b1, int'($urandom_range(15)));
      end
    end
    idle();

    // let the monitor drain, bounded
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
